jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Shares one bank of NBITS JK-style state bits between NREQ requesters.
- Each requester issues J/K commands (hold/reset/set/toggle) to a selected bit index over a valid/ready handshake.
- A round-robin arbiter grants at most one command per cycle. A one-stage apply pipeline then updates the bank with standard JK semantics.
- Sits between control FSMs and the status/flag flops they share.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of JK state bits in the bank (2..32)
- IDXW, 3, bit-index width; must equal clog2(NBITS)
- GIDW, 2, grant-id width; must equal clog2(NREQ)
- CNTW, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- freeze  in  1  when high, no new commands are accepted; the pipeline still drains
- req_valid  in  NREQ  per-requester command valid
- req_j  in  NREQ  per-requester J
- req_k  in  NREQ  per-requester K
- req_idx  in  NREQ*IDXW  per-requester target index; requester i occupies bits [i*IDXW +: IDXW]
- req_ready  out  NREQ  one-hot accept strobe
- q  out  NBITS  bank state
- apply_valid  out  1  high in the cycle a command is being applied
- apply_id  out  GIDW  requester whose command is being applied
- bad_idx  out  1  sticky error flag: an accepted command had idx >= NBITS
- stat_grants  out  NREQ*CNTW  per-requester accepted-command counts (optional feature)

Behaviour:
Reset (reset==0 at a clk edge):
- q=0, rr pointer=0, stage empty.
- apply_valid=0, apply_id=0, bad_idx=0, stat counters=0.
- req_ready is 0 while reset is low.
- Reset mid-operation discards any staged command; the bank is not updated.

Arbitration (combinational, same cycle as the request):
- Search starts at the rr pointer and wraps. The first i with req_valid[i]=1 gets req_ready[i]=1.
- All req_ready are 0 when freeze=1, when reset is low, or when no valid is present.
- Accept happens when req_valid[i] & req_ready[i] at a clk edge.
- On accept, rr pointer <= (i+1) mod NREQ. Otherwise the pointer holds.
- Handshake rule: a requester keeps valid, j, k and idx stable until accepted. The block does not check this.

Stage (registered):
- On accept, the stage captures {id, j, k, idx} and apply_valid<=1. Otherwise apply_valid<=0.
- Throughput is one command per cycle, with no bubble between back-to-back accepts.

Apply (the edge after the stage is loaded):
- The stage updates q[idx]:
  - 00 hold
  - 01 clear to 0
  - 10 set to 1
  - 11 invert the current q[idx]
- Apply latency: a command accepted at edge t is visible on q after edge t+1.
- Consecutive commands to the same idx are applied in order. Each one uses the q value produced by its predecessor, so two toggles return the bit to its original value.
- idx >= NBITS (possible only when NBITS is not a power of two): q is unchanged and bad_idx<=1. bad_idx clears only on reset.
- apply_id shows the staged requester id while apply_valid=1. Otherwise it holds its last value.
- freeze asserted while the stage is loaded: the staged command still applies. Freeze blocks acceptance only.

Optional Feature:
- JK_ARB_STATS_EN defined:
  - Each requester has a CNTW-bit counter that increments on each accept and saturates at all-ones.
  - Counters clear on reset.
  - Counter i occupies stat_grants[i*CNTW +: CNTW].
- Not defined:
  - No counters are synthesized.
  - stat_grants is tied to 0; the port is still present.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all req_valid=1 -> req_ready=0, q=0x00, apply_valid=0, bad_idx=0.
- Single set/toggle: req0 sends J=1,K=0,idx=3, accepted at t -> q=0x08 after t+1. Next, J=1,K=1,idx=3 -> q=0x00. apply_id=0 in both apply cycles.
- Round-robin fairness: all 4 requesters valid continuously with distinct set commands (idx 0..3) -> accept order 0,1,2,3,0; q=0x0F after the 5th edge; each requester granted once per 4 cycles.
- Same-index back-to-back: req1 toggles idx 5 on two consecutive cycles, starting from q[5]=0 -> q[5] reads 1 then 0, no lost update.
- Freeze: a command is staged, then freeze=1 for 3 cycles with valids high -> the staged command applies, req_ready=0 for all 3 cycles, and the rr pointer is unchanged when freeze drops.
- Bad index / stats: NBITS=6, send idx=7 -> q unchanged, bad_idx=1 stays sticky. With JK_ARB_STATS_EN and CNTW=2, 5 accepts from req2 -> its stat_grants field reads 3 (saturated).

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter feeding a shared JK bit bank; JK_ARB_STATS_EN adds per-requester grant counters.
// Accept-to-q latency 2 edges, one command per cycle; freeze or reset holds off all req_ready.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3,
    parameter int GIDW  = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_j,
    input  logic [NREQ-1:0]      req_k,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NBITS-1:0]     q,
    output logic                 apply_valid,
    output logic [GIDW-1:0]      apply_id,
    output logic                 bad_idx,
    output logic [NREQ*CNTW-1:0] stat_grants
);

    logic [GIDW-1:0]  rr_q, rr_d;
    logic             apply_valid_q, apply_valid_d;
    logic [GIDW-1:0]  apply_id_q, apply_id_d;
    logic             stg_j_q, stg_j_d;
    logic             stg_k_q, stg_k_d;
    logic [IDXW-1:0]  stg_idx_q, stg_idx_d;
    logic [NBITS-1:0] bank_q, bank_d;
    logic             bad_idx_q, bad_idx_d;

    logic [NREQ-1:0]  gnt;
    logic [GIDW-1:0]  gnt_id;
    logic             acc;

    // Rotating priority search starting at the pointer
    always_comb begin
        int cand;
        logic found;
        cand   = 0;
        found  = 1'b0;
        gnt    = '0;
        gnt_id = '0;
        for (int o = 0; o < NREQ; o++) begin
            cand = (int'(rr_q) + o) % NREQ;
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_id    = GIDW'(cand);
            end
        end
        if (freeze || !reset) begin
            gnt = '0;
        end
        acc = |gnt;
    end

    assign req_ready = gnt;

    always_comb begin
        rr_d          = rr_q;
        apply_valid_d = acc;
        apply_id_d    = apply_id_q;
        stg_j_d       = stg_j_q;
        stg_k_d       = stg_k_q;
        stg_idx_d     = stg_idx_q;
        bank_d        = bank_q;
        bad_idx_d     = bad_idx_q;

        if (acc) begin
            rr_d       = GIDW'((int'(gnt_id) + 1) % NREQ);
            apply_id_d = gnt_id;
            stg_j_d    = req_j[gnt_id];
            stg_k_d    = req_k[gnt_id];
            stg_idx_d  = req_idx[int'(gnt_id)*IDXW +: IDXW];
        end

        // Apply reads bank_q, which already holds any predecessor's result
        if (apply_valid_q) begin
            if (int'(stg_idx_q) >= NBITS) begin
                bad_idx_d = 1'b1;
            end else begin
                for (int b = 0; b < NBITS; b++) begin
                    if (stg_idx_q == IDXW'(b)) begin
                        case ({stg_j_q, stg_k_q})
                            2'b01:   bank_d[b] = 1'b0;
                            2'b10:   bank_d[b] = 1'b1;
                            2'b11:   bank_d[b] = ~bank_q[b];
                            default: bank_d[b] = bank_q[b];
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q          <= '0;
            apply_valid_q <= 1'b0;
            apply_id_q    <= '0;
            stg_j_q       <= 1'b0;
            stg_k_q       <= 1'b0;
            stg_idx_q     <= '0;
            bank_q        <= '0;
            bad_idx_q     <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            apply_valid_q <= apply_valid_d;
            apply_id_q    <= apply_id_d;
            stg_j_q       <= stg_j_d;
            stg_k_q       <= stg_k_d;
            stg_idx_q     <= stg_idx_d;
            bank_q        <= bank_d;
            bad_idx_q     <= bad_idx_d;
        end
    end

    assign q           = bank_q;
    assign apply_valid = apply_valid_q;
    assign apply_id    = apply_id_q;
    assign bad_idx     = bad_idx_q;

`ifdef JK_ARB_STATS_EN
    logic [CNTW-1:0] cnt_q [NREQ];
    logic [CNTW-1:0] cnt_d [NREQ];

    // Saturating accept counters
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[i*CNTW +: CNTW] = cnt_q[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule
